// File: rtl/example_expander.sv
// example_expander: registered 4-bit code expander.
// Samples data_in on every rising clk edge. data_out is a registered status word:
//   [31:28] current code, [27:24] previous code, [23:8] one-hot decode of the
//   current code, [7:0] count of edges that sampled a changed code.
// Optional build macro EXAMPLE_EXPANDER_PARITY_EN: data_out[7] carries the parity
// of the current code, and the counter shrinks to 7 bits in data_out[6:0].
module example_expander (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  data_in,
  output logic [31:0] data_out
);

`ifdef EXAMPLE_EXPANDER_PARITY_EN
  localparam int CNT_W = 7;
`else
  localparam int CNT_W = 8;
`endif

  logic [3:0]       code_q, code_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [15:0]      onehot;

  // Next state: sample the code, shift the old one, and count only real changes.
  always_comb begin
    code_d = data_in;
    prev_d = code_q;
    cnt_d  = cnt_q;
    if (data_in != code_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset leaves every register defined, so data_out carries no X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= 4'h0;
      prev_q <= 4'h0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  // One-hot decode of the registered code; exactly one bit is ever set.
  always_comb begin
    onehot         = 16'h0000;
    onehot[code_q] = 1'b1;
  end

  // Output packing is pure wiring of register-derived values.
`ifdef EXAMPLE_EXPANDER_PARITY_EN
  assign data_out = {code_q, prev_q, onehot, ^code_q, cnt_q};
`else
  assign data_out = {code_q, prev_q, onehot, cnt_q};
`endif

endmodule

// File: tb/tb_example_expander.sv
// Testbench for example_expander: table of hand-computed vectors plus
// scoreboard-driven sequences for reset, sweep, hold and counter wrap.
module tb_example_expander;

  logic        clk;
  logic        rst;
  logic [3:0]  data_in;
  logic [31:0] data_out;

  int total;
  int bad;

  logic [31:0] exp_q[$];

  logic [3:0]  m_code;
  logic [3:0]  m_prev;
  logic [7:0]  m_cnt;

  typedef struct {
    logic [3:0]  din;
    logic [31:0] exp_def;
    logic [31:0] exp_par;
  } vec_t;

  vec_t vecs[7];

  example_expander dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [3:0] c, input logic [3:0] p,
                                             input logic [7:0] n);
    logic [15:0] oh;
    oh = 16'h0001 << c;
`ifdef EXAMPLE_EXPANDER_PARITY_EN
    return {c, p, oh, ^c, n[6:0]};
`else
    return {c, p, oh, n};
`endif
  endfunction

  task automatic model_reset();
    m_code = 4'h0;
    m_prev = 4'h0;
    m_cnt  = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] d);
    if (d != m_code) m_cnt = m_cnt + 8'd1;
    m_prev = m_code;
    m_code = d;
  endtask

  // Drive one sample, push its expected word, then pop and compare after the edge.
  task automatic drive(input string name, input logic [3:0] d, input logic [31:0] exp);
    logic [31:0] e;
    data_in = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_empty_queue"}, data_out, 32'hDEAD_BEEF);
    end else begin
      e = exp_q.pop_front();
      check(name, data_out, e);
    end
  endtask

  task automatic step(input string name, input logic [3:0] d);
    model_step(d);
    drive(name, d, model_word(m_code, m_prev, m_cnt));
  endtask

  // Assert reset between edges, then release between edges.
  task automatic pulse_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_async", data_out, 32'h0000_0100);
    #2;
    rst = 1'b0;
  endtask

  logic [31:0] hold_val;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{4'h1, 32'h1000_0201, 32'h1000_0281};
    vecs[1] = '{4'h1, 32'h1100_0201, 32'h1100_0281};
    vecs[2] = '{4'h3, 32'h3100_0802, 32'h3100_0802};
    vecs[3] = '{4'h0, 32'h0300_0103, 32'h0300_0103};
    vecs[4] = '{4'h0, 32'h0000_0103, 32'h0000_0103};
    vecs[5] = '{4'hF, 32'hF080_0004, 32'hF080_0004};
    vecs[6] = '{4'h8, 32'h8F01_0005, 32'h8F01_0085};

    rst     = 1'b1;
    data_in = 4'h0;
    model_reset();
    #12;
    check("reset_initial", data_out, 32'h0000_0100);
    check("reset_no_x", 32'(!$isunknown(data_out)), 32'd1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors starting from reset state.
    pulse_reset();
    @(posedge clk);
    #1;
    model_reset();
    check("first_edge_zero", data_out, 32'h0000_0100);
    for (int i = 0; i < 7; i++) begin
`ifdef EXAMPLE_EXPANDER_PARITY_EN
      drive($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_par);
`else
      drive($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_def);
`endif
      model_step(vecs[i].din);
    end

    // Asynchronous reset mid-cycle with a nonzero input; it must hold across edges.
    data_in = 4'hA;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_mid_cycle", data_out, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      data_in = 4'(i * 5 + 2);
      @(posedge clk);
      #1;
      check("reset_held", data_out, 32'h0000_0100);
    end
    #3;
    rst = 1'b0;

    // Full sweep 0..F with a one-hot check on every edge.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%0d", i), 4'(i));
      check("sweep_onehot", 32'($onehot(data_out[23:8])), 32'd1);
    end
    check("sweep_final", data_out, 32'hFE80_000F);

    // Hold a constant code for 50 edges.
    step("hold_load", 4'h6);
    step("hold_settle", 4'h6);
    hold_val = data_out;
    for (int i = 0; i < 50; i++) begin
      step("hold", 4'h6);
      check("hold_stable", data_out, hold_val);
    end

    // Counter wrap: 256 changes from a clean reset.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      step("wrap", 4'((i + 1) % 2));
      if (i == 127) begin
`ifdef EXAMPLE_EXPANDER_PARITY_EN
        check("wrap_128", 32'(data_out[6:0]), 32'h00);
`else
        check("wrap_128", 32'(data_out[7:0]), 32'h80);
`endif
      end
    end
`ifdef EXAMPLE_EXPANDER_PARITY_EN
    check("wrap_256", 32'(data_out[6:0]), 32'h00);
`else
    check("wrap_256", 32'(data_out[7:0]), 32'h00);
`endif
    step("wrap_next", 4'h1);
`ifdef EXAMPLE_EXPANDER_PARITY_EN
    check("wrap_plus1", 32'(data_out[6:0]), 32'h01);
`else
    check("wrap_plus1", 32'(data_out[7:0]), 32'h01);
`endif

    // Reset mid-operation after the counter reaches 5, then resume with code 3.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      step("pre_reset", 4'(i + 1));
    end
    check("cnt_is_5", 32'(data_out[6:0]), 32'h05);
    pulse_reset();
    step("resume", 4'h3);
    check("resume_word", data_out, 32'h3000_0801);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/example_expander.md
# example_expander

Registered code expander: samples a 4-bit code every clock and presents a 32-bit status word with the current code, the previous code, a 16-bit one-hot decode and a change counter. It sits between a small control source and wide downstream logic that needs a pre-decoded, registered view of the code. A 16-value sweep of the input is its primary use case.

## Interface

- No parameters; all widths are fixed.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  4  code to sample.
- data_out  output  32  registered status word; layout is given under Operation.

## Operation

State registers:
- code_q[3:0]: current code.
- prev_q[3:0]: previous code.
- cnt_q[7:0]: change counter.

On each rising clk edge while rst is low:
- code_q <= data_in.
- prev_q <= code_q.
- cnt_q <= cnt_q + 1 when data_in != code_q; otherwise cnt_q holds.
- cnt_q is modulo-256: 8'hFF + 1 = 8'h00.

data_out is a purely combinational function of the registers; no logic may sit between data_in and data_out. Field layout:
- [31:28] = code_q.
- [27:24] = prev_q.
- [23:8] = one-hot decode of code_q: exactly one bit is set, at position 8 + code_q.
- [7:0] = cnt_q.

Other requirements:
- All arithmetic is unsigned.
- The input comparison is a full 4-bit compare.
- No X may propagate after reset.

## Timing

- Latency: a data_in change is visible on data_out one clock edge after it is sampled.
- [27:24] shows that code one edge later again.
- The counter increments on the same edge where [31:28] changes.
- Reset asserts asynchronously, at any time including mid-sweep:
  - code_q = 0, prev_q = 0, cnt_q = 0.
  - data_out = 32'h0000_0100.
- While rst is high, data_out holds 32'h0000_0100 regardless of clk or data_in.
- On release, the first rising edge with rst low samples normally.
- An edge that samples an unchanged code does not increment the counter. This includes the first edge after reset when data_in = 0.
- There is no handshake. Every edge is a sample.
- No input metastability handling; data_in is synchronous to clk.

## Configuration

Macro: EXAMPLE_EXPANDER_PARITY_EN.
- Defined:
  - data_out[7] = XOR-reduction of code_q (odd-weight code gives 1).
  - The counter is 7 bits in data_out[6:0] and wraps 7'h7F -> 7'h00.
  - Reset value is unchanged: 32'h0000_0100.
- Not defined: the 8-bit counter occupies [7:0] as described under Operation.
- All other fields and all timing are identical in both builds.

## Test plan

1. Reset: assert rst asynchronously mid-cycle with data_in = 4'hA.
   - data_out = 32'h0000_0100 immediately.
   - It stays there until rst is released.
2. Single change: after reset, data_in = 1.
   - Next edge: 32'h1000_0201.
   - Hold data_in = 1 for one more edge: 32'h1100_0201, with the counter unchanged.
   - With EXAMPLE_EXPANDER_PARITY_EN defined, the first value is 32'h1000_0281.
3. Sweep: after reset, drive data_in = 0..F, one edge each.
   - After the F edge: 32'hFE80_000F in both builds (parity of F is 0).
   - At every edge, exactly one bit of [23:8] is set.
4. Counter wrap: alternate data_in 0/1 for 256 changes.
   - Without the macro: cnt reads 8'h00, then 8'h01 on the next change.
   - With the macro: [6:0] wraps after 128 changes.
5. Hold: keep data_in constant for 50 edges.
   - data_out is stable.
   - [31:28] == [27:24].
   - The counter does not move.
6. Reset mid-operation: set the counter to 5, then pulse rst between edges.
   - data_out returns to 32'h0000_0100.
   - Resume with data_in = 3: the next edge gives 32'h3000_0801.
